// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// byte-feeder state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        F_IDLE      = 2'd0,
        F_WAIT_BUSY = 2'd1,
        F_WAIT_DONE = 2'd2,
        F_WAIT_IDLE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and a combinational
// head-of-queue read port. Flush takes priority over push and pop.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [ADDR_W:0]  level,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push_en;
    logic              pop_en;

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    // Storage needs no reset; entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes in a FIFO and feeds them one at a time into the
// UART transmitter's start/data/busy/done handshake.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [UART_DATA_W-1:0] in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [ADDR_W:0]        level,
    output logic                   empty,
    output logic                   overflow
);

    feeder_state_t          state;
    feeder_state_t          state_d;
    logic                   tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_d;
    logic [UART_DATA_W-1:0] head;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Producer side: a byte transfers on any edge where in_valid && in_ready.
    // in_ready depends only on the registered level, never on in_valid, and
    // a byte offered while in_ready is low is dropped and flagged in overflow.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !flush;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_data),
        .rd_data (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= F_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
        end
    end

    // Start is held until busy is seen because the transmitter samples it a
    // cycle late; the wait on busy falling covers its done/cleanup cycle.
    always_comb begin
        state_d    = state;
        tx_start_d = tx_start;
        tx_data_d  = tx_data;
        pop        = 1'b0;
        case (state)
            F_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    tx_data_d  = head;
                    tx_start_d = 1'b1;
                    pop        = 1'b1;
                    state_d    = F_WAIT_BUSY;
                end
            end
            F_WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = F_WAIT_DONE;
                end
            end
            F_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = F_WAIT_IDLE;
                end
            end
            F_WAIT_IDLE: begin
                if (!tx_busy) begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = F_IDLE;
            end
        endcase
    end

    assign empty = fifo_empty && (state == F_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a behavioural UART
// transmitter (4 clocks per bit) and a queue-based model of the byte buffer.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CPB   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] level;
    logic       empty;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .level    (level),
        .empty    (empty),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural transmitter: registers start, accepts it when idle, raises
    // busy after busy_delay extra cycles, shifts a 10-bit frame LSB first,
    // then holds done and busy together for one cleanup cycle.
    int         busy_delay = 0;
    int         tx_phase;
    int         dly_cnt;
    int         bit_idx;
    int         clk_cnt;
    int         n_done = 0;
    logic       start_s;
    logic       tx_line;
    logic [9:0] frame_r;
    logic [7:0] sent_q[$];
    logic       bits_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_line  <= 1'b1;
            start_s  <= 1'b0;
            tx_phase <= 0;
            dly_cnt  <= 0;
            bit_idx  <= 0;
            clk_cnt  <= 0;
            frame_r  <= '0;
        end else begin
            start_s <= tx_start;
            tx_done <= 1'b0;
            case (tx_phase)
                0: if (start_s) begin
                    frame_r  <= {1'b1, tx_data, 1'b0};
                    sent_q.push_back(tx_data);
                    tx_phase <= 1;
                    dly_cnt  <= busy_delay;
                end
                1: if (dly_cnt == 0) begin
                    tx_phase <= 2;
                    tx_busy  <= 1'b1;
                    tx_line  <= frame_r[0];
                    bits_q.push_back(frame_r[0]);
                    bit_idx  <= 0;
                    clk_cnt  <= 0;
                end else begin
                    dly_cnt <= dly_cnt - 1;
                end
                2: if (clk_cnt == CPB - 1) begin
                    clk_cnt <= 0;
                    if (bit_idx == 9) begin
                        tx_phase <= 3;
                        tx_done  <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1;
                        tx_line <= frame_r[bit_idx + 1];
                        bits_q.push_back(frame_r[bit_idx + 1]);
                    end
                end else begin
                    clk_cnt <= clk_cnt + 1;
                end
                default: begin
                    tx_busy  <= 1'b0;
                    tx_phase <= 0;
                    n_done++;
                end
            endcase
        end
    end

    // Reference model: a queue of bytes accepted but not yet handed to the
    // transmitter, plus the sticky overflow flag.
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    int         n_starts  = 0;
    int         n_push    = 0;

    always @(posedge clk) begin
        logic       r0, acc, ovf_try, fl, st0, busy0;
        logic [7:0] d0, head;
        logic       have;
        r0      = rst_n;
        acc     = in_valid && in_ready && !flush;
        ovf_try = in_valid && !in_ready && !flush;
        fl      = flush;
        d0      = in_data;
        st0     = tx_start;
        busy0   = tx_busy;
        #1;
        if (!r0 || !rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (tx_start && !st0) begin
                n_starts++;
                check("start_while_busy", 32'(busy0), 32'd0);
                have = (model_q.size() > 0);
                head = have ? model_q.pop_front() : 8'h00;
                check("issue_data", {23'd0, 1'b1, tx_data}, {23'd0, have, head});
            end
            if (fl) model_q.delete();
            else if (acc) model_q.push_back(d0);
            if (fl) model_ovf = 1'b0;
            else if (ovf_try) model_ovf = 1'b1;
            if (acc) n_push++;
            check("level", 32'(level), 32'(model_q.size()));
            check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
            check("overflow", 32'(overflow), 32'(model_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tx_start"}, 32'(tx_start), 32'd0);
        check({pfx, "_tx_data"}, 32'(tx_data), 32'h00);
        check({pfx, "_level"}, 32'(level), 32'd0);
        check({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        check({pfx, "_empty"}, 32'(empty), 32'd1);
        check({pfx, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic wait_busy(input logic v, input int max_cyc, input string tag);
        int n = 0;
        while (tx_busy !== v && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_busy === v), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (!(empty === 1'b1 && tx_busy === 1'b0 && tx_start === 1'b0 && tx_phase == 0)
               && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(empty === 1'b1 && tx_busy === 1'b0), 32'd1);
    endtask

    task automatic push_one(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [9:0] line_bits();
        logic [9:0] got = '1;
        for (int i = 0; i < 10 && i < bits_q.size(); i++) got[9 - i] = bits_q[i];
        return got;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int s0, d0, p0, n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        flush    = 1'b0;
        #1;
        check_reset("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single byte: start two edges after the push, known serial frame
        sent_q.delete();
        bits_q.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("t1_start_e1", 32'(tx_start), 32'd0);
        check("t1_level_e1", 32'(level), 32'd1);
        tick();
        check("t1_start_e2", 32'(tx_start), 32'd1);
        check("t1_data", 32'(tx_data), 32'hA5);
        check("t1_not_empty", 32'(empty), 32'd0);
        wait_busy(1'b1, 20, "t1_busy_up");
        wait_busy(1'b0, 200, "t1_busy_down");
        tick();
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_nbits", 32'(bits_q.size()), 32'd10);
        check("t1_line", 32'(line_bits()), 32'(10'b0101001011));

        // Three-byte burst on consecutive cycles
        sent_q.delete();
        s0 = n_starts;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_idle(600, "t2_drain");
        check("t2_starts", 32'(n_starts - s0), 32'd3);
        check("t2_nsent", 32'(sent_q.size()), 32'd3);
        check("t2_order", {8'd0, sent_q[0], sent_q[1], sent_q[2]}, 32'h00010203);

        // Fill to full, overflow, then flush while a byte is in flight
        sent_q.delete();
        s0 = n_starts;
        d0 = n_done;
        in_valid = 1'b1;
        n = 0;
        while (in_ready === 1'b1 && n < 40) begin
            in_data = 8'($urandom_range(0, 255));
            tick();
            n++;
        end
        check("t3_level_full", 32'(level), 32'd16);
        check("t3_ready_low", 32'(in_ready), 32'd0);
        check("t3_ovf_before", 32'(overflow), 32'd0);
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("t3_ovf_set", 32'(overflow), 32'd1);
        check("t3_level_hold", 32'(level), 32'd16);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_level", 32'(level), 32'd0);
        check("t3_flush_ovf", 32'(overflow), 32'd0);
        check("t3_flush_ready", 32'(in_ready), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t3_flush_push_level", 32'(level), 32'd0);
        check("t3_flush_push_ovf", 32'(overflow), 32'd0);
        wait_idle(300, "t3_drain");
        check("t3_starts", 32'(n_starts - s0), 32'd1);
        check("t3_done", 32'(n_done - d0), 32'd1);
        check("t3_nsent", 32'(sent_q.size()), 32'd1);

        // Push and pop on the same edge, then random traffic past the wrap
        s0 = n_starts;
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check("t4_level_pushpop", 32'(level), 32'd1);
        check("t4_start", 32'(tx_start), 32'd1);
        p0 = n_push;
        n  = 0;
        while (n_push - p0 < 18 && n < 4000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom_range(0, 255));
            tick();
            n++;
        end
        in_valid = 1'b0;
        wait_idle(3000, "t4_drain");
        check("t4_starts", 32'(n_starts - s0), 32'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);

        // Asynchronous reset during the data bits of 0x3C, then a clean 0x55
        bits_q.delete();
        push_one(8'h3C);
        n = 0;
        while (bits_q.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        check("t5_in_data_phase", 32'(bits_q.size() >= 3), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("t5_async");
        check("t5_busy_cleared", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bits_q.delete();
        sent_q.delete();
        tick();
        s0 = n_starts;
        push_one(8'h55);
        wait_idle(300, "t5_drain");
        check("t5_starts", 32'(n_starts - s0), 32'd1);
        check("t5_byte", 32'(sent_q.size() == 1 ? sent_q[0] : 8'h00), 32'h55);
        check("t5_line", 32'(line_bits()), 32'(10'b0101010101));

        // Transmitter slow to raise busy: start and data must hold
        busy_delay = 3;
        sent_q.delete();
        s0 = n_starts;
        push_one(8'h9E);
        tick();
        check("t6_start", 32'(tx_start), 32'd1);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            check("t6_start_hold", 32'(tx_start), 32'd1);
            check("t6_data_hold", 32'(tx_data), 32'h9E);
            tick();
            n++;
        end
        check("t6_busy_seen", 32'(tx_busy), 32'd1);
        check("t6_start_at_busy", 32'(tx_start), 32'd1);
        tick();
        check("t6_start_drop", 32'(tx_start), 32'd0);
        wait_idle(300, "t6_drain");
        busy_delay = 0;
        check("t6_starts", 32'(n_starts - s0), 32'd1);
        check("t6_nsent", 32'(sent_q.size()), 32'd1);
        check("t6_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
